ram_bank: RTL

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/mini_cpu_pkg.sv | 14 +
 rtl/ram_array.sv | 20 ++
 rtl/ram_bank.sv | 95 +++++++++
 3 files changed

// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: CPU state, opcode and sweep encodings shared by the CPU control block and RAM bank
package mini_cpu_pkg;
    typedef enum logic [2:0] {
        ST_OFF, ST_FETCH, ST_DECODE, ST_READ, ST_CALC, ST_DISPLAY, ST_STORE
    } cpu_state_t;
    typedef enum logic [2:0] {
        OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_CLEAR, OP_DISPLAY
    } opcode_t;
    typedef enum logic [1:0] {SW_IDLE, SW_CLEARING, SW_DONE} sweep_t;
    // bit 0: opcode loads v1 from addr1, bit 1: opcode loads v2 from addr2
    function automatic logic [1:0] read_sel(opcode_t op);
        return {op == OP_ADD || op == OP_SUB, op != OP_LOAD && op != OP_CLEAR};
    endfunction
endpackage

// File: rtl/ram_array.sv
// ram_array: word storage with two asynchronous read ports and one synchronous write port
module ram_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/ram_bank.sv
// ram_bank: CPU operand RAM with state-entry triggered read/store handshakes and a clear sweep
module ram_bank import mini_cpu_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        state_cpu,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] v1,
    output logic [DATA_W-1:0] v2,
    output logic              read,
    output logic              stored,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] LAST = '1;
    logic [2:0]        prev;
    sweep_t            sw, sw_nx;
    logic [ADDR_W-1:0] idx, waddr;
    logic [DATA_W-1:0] wval, rdata_a, rdata_b;
    logic              quiet, pend, we, rd_entry, st_entry;
    opcode_t           op, pend_op;
    logic [1:0]        sel, pend_sel;

    assign op       = opcode_t'(opcode);
    assign sel      = read_sel(op);
    assign pend_sel = read_sel(pend_op);
    assign rd_entry = state_cpu == ST_READ && prev != ST_READ;
    assign st_entry = state_cpu == ST_STORE && prev != ST_STORE;
    assign busy     = sw == SW_CLEARING;

    ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
        .clk(clk), .we(we), .waddr(waddr), .wdata(wval),
        .raddr_a(addr1), .raddr_b(addr2), .rdata_a(rdata_a), .rdata_b(rdata_b)
    );

    always_comb begin
        sw_nx = sw;
        we    = 1'b0;
        waddr = idx;
        wval  = '0;
        if (busy) begin
            we    = 1'b1;
            sw_nx = idx == LAST ? SW_DONE : SW_CLEARING;
        end else if (st_entry) begin
            sw_nx = op == OP_CLEAR ? SW_CLEARING : SW_IDLE;
            we    = op != OP_CLEAR && op != OP_DISPLAY;
            waddr = op == OP_LOAD ? addr1 : (op == OP_ADD || op == OP_SUB) ? addr3 : addr2;
            wval  = wdata;
        end else if (sw == SW_DONE) begin
            sw_nx = SW_IDLE;
        end
    end

    // quiet marks a reset-initiated sweep, whose DONE cycle must not pulse stored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= ST_OFF;
            sw      <= SW_CLEARING;
            idx     <= '0;
            quiet   <= 1'b1;
            pend    <= 1'b0;
            pend_op <= OP_LOAD;
            v1      <= '0;
            v2      <= '0;
            read    <= 1'b0;
            stored  <= 1'b0;
        end else begin
            prev   <= state_cpu;
            sw     <= sw_nx;
            idx    <= busy && idx != LAST ? idx + 1'b1 : '0;
            read   <= 1'b0;
            stored <= (sw == SW_DONE && !quiet) || (st_entry && !busy && op != OP_CLEAR);
            if (sw == SW_DONE) quiet <= 1'b0;
            if (rd_entry && busy) begin
                pend    <= 1'b1;
                pend_op <= op;
            end
            if (sw == SW_DONE && pend) begin
                pend <= 1'b0;
                read <= 1'b1;
                if (pend_sel[0]) v1 <= '0;
                if (pend_sel[1]) v2 <= '0;
            end else if (rd_entry && !busy) begin
                read <= 1'b1;
                if (sel[0]) v1 <= rdata_a;
                if (sel[1]) v2 <= rdata_b;
            end
        end
    end
endmodule
